// File: rtl/qq_pkg.sv
// Shared types and default sizing for the Quick Priority Queue drain controller.
// The optional watchdog is enabled by defining QQ_DRAIN_TIMEOUT_EN.
package qq_pkg;

   localparam int QQ_DEPTH       = 16;
   localparam int QQ_KEY_W       = 16;
   localparam int QQ_TIMEOUT_CYC = 64;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      DRAIN = 2'd1,
      FLUSH = 2'd2,
      DONE  = 2'd3
   } drain_state_t;

   function automatic int cnt_w(input int depth);
      return $clog2(depth + 1);
   endfunction

endpackage

// File: rtl/qq_drain_ctl_if.sv
// Handshake/status bundle between the queue, the drain controller and downstream.
// slave = drain controller side, master = queue/downstream/environment side.
interface qq_drain_ctl_if #(
   parameter int KEY_W = qq_pkg::QQ_KEY_W,
   parameter int CNT_W = qq_pkg::cnt_w(qq_pkg::QQ_DEPTH)
);

   logic             enq_fire;
   logic             drain_start;
   logic             deq_req;
   logic             deq_ack;
   logic [KEY_W-1:0] deq_key;
   logic             out_valid;
   logic             out_ready;
   logic [KEY_W-1:0] out_key;
   logic [CNT_W-1:0] occ;
   logic             busy;
   logic             drain_done;
   logic             ovf_err;
   logic             unf_err;
   logic             timeout_err;

   modport slave (
      input  enq_fire, drain_start, deq_ack, deq_key, out_ready,
      output deq_req, out_valid, out_key, occ, busy, drain_done,
             ovf_err, unf_err, timeout_err
   );

   modport master (
      output enq_fire, drain_start, deq_ack, deq_key, out_ready,
      input  deq_req, out_valid, out_key, occ, busy, drain_done,
             ovf_err, unf_err, timeout_err
   );

endinterface

// File: rtl/qq_occ_cnt.sv
// Saturating up/down occupancy counter with sticky overflow/underflow flags.
module qq_occ_cnt #(
   parameter int DEPTH = qq_pkg::QQ_DEPTH,
   parameter int CNT_W = $clog2(DEPTH + 1)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             inc_i,
   input  logic             dec_req_i,
   input  logic             dec_ack_i,
   output logic [CNT_W-1:0] occ_o,
   output logic [CNT_W-1:0] occ_next_o,
   output logic             dec_fire_o,
   output logic             ovf_err_o,
   output logic             unf_err_o
);

   localparam logic [CNT_W-1:0] FULL = CNT_W'(DEPTH);

   logic [CNT_W-1:0] occ_q, occ_d;
   logic             ovf_q, ovf_d;
   logic             unf_q, unf_d;
   logic             dec_fire;
   logic             ovf_evt;
   logic             unf_evt;

   always_comb begin
      dec_fire = dec_req_i & dec_ack_i & (occ_q != '0);
      ovf_evt  = inc_i & (occ_q == FULL) & ~dec_fire;
      unf_evt  = dec_ack_i & (~dec_req_i | (occ_q == '0));
      occ_d    = occ_q;
      if (inc_i & ~ovf_evt & ~dec_fire) begin
         occ_d = occ_q + CNT_W'(1);
      end else if (dec_fire & ~inc_i) begin
         occ_d = occ_q - CNT_W'(1);
      end
      ovf_d = ovf_q | ovf_evt;
      unf_d = unf_q | unf_evt;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         occ_q <= '0;
         ovf_q <= 1'b0;
         unf_q <= 1'b0;
      end else begin
         occ_q <= occ_d;
         ovf_q <= ovf_d;
         unf_q <= unf_d;
      end
   end

   assign occ_o      = occ_q;
   assign occ_next_o = occ_d;
   assign dec_fire_o = dec_fire;
   assign ovf_err_o  = ovf_q;
   assign unf_err_o  = unf_q;

endmodule

// File: rtl/qq_drain_ctl.sv
// Drain-side controller: dequeues until empty, registers keys downstream, pulses drain_done.
// Define QQ_DRAIN_TIMEOUT_EN to add the dequeue-ack watchdog.
//
//   state | meaning
//   IDLE  | waiting for drain_start
//   DRAIN | issuing deq_req while the output stage has room
//   FLUSH | no more requests; waiting for the last key to leave
//   DONE  | one-cycle drain_done pulse
module qq_drain_ctl
   import qq_pkg::*;
#(
   parameter int DEPTH = QQ_DEPTH,
   parameter int KEY_W = QQ_KEY_W
`ifdef QQ_DRAIN_TIMEOUT_EN
   ,
   parameter int TIMEOUT_CYC = QQ_TIMEOUT_CYC
`endif
) (
   input  logic          clk,
   input  logic          rst,
   qq_drain_ctl_if.slave qq_if
);

   localparam int CNT_W = $clog2(DEPTH + 1);

   drain_state_t     state_q, state_d;
   logic             out_valid_q, out_valid_d;
   logic [KEY_W-1:0] out_key_q, out_key_d;
   logic [CNT_W-1:0] occ;
   logic [CNT_W-1:0] occ_next;
   logic             capture;
   logic             deq_req;
   logic             timeout_hit;

   qq_occ_cnt #(
      .DEPTH (DEPTH),
      .CNT_W (CNT_W)
   ) u_occ_cnt (
      .clk        (clk),
      .rst        (rst),
      .inc_i      (qq_if.enq_fire),
      .dec_req_i  (deq_req),
      .dec_ack_i  (qq_if.deq_ack),
      .occ_o      (occ),
      .occ_next_o (occ_next),
      .dec_fire_o (capture),
      .ovf_err_o  (qq_if.ovf_err),
      .unf_err_o  (qq_if.unf_err)
   );

   assign deq_req = (state_q == DRAIN) & (~out_valid_q | qq_if.out_ready);

`ifdef QQ_DRAIN_TIMEOUT_EN
   localparam int WD_W = $clog2(TIMEOUT_CYC + 1);
   localparam logic [WD_W-1:0] WD_LOAD = WD_W'(TIMEOUT_CYC - 1);

   logic [WD_W-1:0] wd_q, wd_d;
   logic            to_err_q, to_err_d;

   // Down-counter reloads on ack or outside DRAIN; holds while backpressured.
   always_comb begin
      wd_d        = wd_q;
      timeout_hit = 1'b0;
      if ((state_q != DRAIN) | qq_if.deq_ack) begin
         wd_d = WD_LOAD;
      end else if (deq_req) begin
         if (wd_q == '0) begin
            timeout_hit = 1'b1;
            wd_d        = WD_LOAD;
         end else begin
            wd_d = wd_q - WD_W'(1);
         end
      end
      to_err_d = to_err_q | timeout_hit;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wd_q     <= WD_LOAD;
         to_err_q <= 1'b0;
      end else begin
         wd_q     <= wd_d;
         to_err_q <= to_err_d;
      end
   end

   assign qq_if.timeout_err = to_err_q;
`else
   assign timeout_hit       = 1'b0;
   assign qq_if.timeout_err = 1'b0;
`endif

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE: begin
            if (qq_if.drain_start) begin
               state_d = (occ != '0) ? DRAIN : DONE;
            end
         end
         DRAIN: begin
            if (timeout_hit || (occ_next == '0)) begin
               state_d = FLUSH;
            end
         end
         FLUSH: begin
            if (~out_valid_q | qq_if.out_ready) begin
               state_d = DONE;
            end
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // A same-cycle capture wins over the downstream accept.
   always_comb begin
      out_valid_d = out_valid_q;
      out_key_d   = out_key_q;
      if (capture) begin
         out_valid_d = 1'b1;
         out_key_d   = qq_if.deq_key;
      end else if (qq_if.out_ready) begin
         out_valid_d = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= IDLE;
         out_valid_q <= 1'b0;
         out_key_q   <= '0;
      end else begin
         state_q     <= state_d;
         out_valid_q <= out_valid_d;
         out_key_q   <= out_key_d;
      end
   end

   assign qq_if.deq_req    = deq_req;
   assign qq_if.out_valid  = out_valid_q;
   assign qq_if.out_key    = out_key_q;
   assign qq_if.occ        = occ;
   assign qq_if.busy       = (state_q != IDLE);
   assign qq_if.drain_done = (state_q == DONE);

endmodule

// File: tb/tb_qq_drain_ctl.sv
// Directed bench for qq_drain_ctl with a key scoreboard; QQ_DRAIN_TIMEOUT_EN selects the watchdog case.
module tb_qq_drain_ctl;
   import qq_pkg::*;

   logic clk;
   logic rst;

   qq_drain_ctl_if qif ();

   qq_drain_ctl dut (
      .clk   (clk),
      .rst   (rst),
      .qq_if (qif)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_checks = 0;
   int n_errors = 0;

   logic [15:0] src_q[$];
   logic [15:0] sb_q[$];

   int keys_out, done_cnt, first_acc, last_acc, done_cyc, req_cnt;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp)
      else begin
         n_errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic enq(input logic [15:0] k);
      qif.enq_fire = 1'b1;
      src_q.push_back(k);
      step();
      qif.enq_fire = 1'b0;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      step();
      step();
      rst = 1'b0;
   endtask

   // Acts as the queue (ack every request) and as a ready downstream until drain_done.
   task automatic drain_loop(input int max_cyc);
      logic [15:0] k;
      keys_out  = 0;
      done_cnt  = 0;
      first_acc = -1;
      last_acc  = -1;
      done_cyc  = -100;
      req_cnt   = 0;
      for (int c = 0; c < max_cyc; c++) begin
         qif.out_ready = 1'b1;
         #1;
         if (qif.deq_req) req_cnt++;
         if (qif.deq_req && src_q.size() > 0) begin
            k = src_q.pop_front();
            qif.deq_ack = 1'b1;
            qif.deq_key = k;
            sb_q.push_back(k);
         end else begin
            qif.deq_ack = 1'b0;
            qif.deq_key = 16'hDEAD;
         end
         if (qif.out_valid && qif.out_ready) begin
            if (sb_q.size() == 0) begin
               check("sb_nonempty", sb_q.size(), 1);
            end else begin
               check("out_key", qif.out_key, sb_q.pop_front());
            end
            keys_out++;
            if (first_acc < 0) first_acc = c;
            last_acc = c;
         end
         if (qif.drain_done) begin
            done_cnt++;
            done_cyc = c;
         end
         step();
         if (done_cnt > 0 && c == done_cyc + 1) break;
      end
      qif.deq_ack = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "time limit");
   end

   initial begin
      int w;
      int dn;
      logic [15:0] k0;

      rst             = 1'b1;
      qif.enq_fire    = 1'b0;
      qif.drain_start = 1'b0;
      qif.deq_ack     = 1'b0;
      qif.deq_key     = '0;
      qif.out_ready   = 1'b0;

      // Reset state
      step();
      step();
      check("rst_occ", qif.occ, 0);
      check("rst_out_valid", qif.out_valid, 0);
      check("rst_out_key", qif.out_key, 0);
      check("rst_deq_req", qif.deq_req, 0);
      check("rst_drain_done", qif.drain_done, 0);
      check("rst_busy", qif.busy, 0);
      check("rst_errs", {qif.ovf_err, qif.unf_err, qif.timeout_err}, 0);
      rst = 1'b0;
      step();

      // 1: three keys drained in order at full throughput
      enq(16'hA001);
      enq(16'hA002);
      enq(16'hA003);
      check("t1_occ3", qif.occ, 3);
      qif.drain_start = 1'b1;
      step();
      qif.drain_start = 1'b0;
      check("t1_busy", qif.busy, 1);
      check("t1_first_req", qif.deq_req, 1);
      drain_loop(60);
      check("t1_keys", keys_out, 3);
      check("t1_done_cnt", done_cnt, 1);
      check("t1_done_lat", done_cyc, last_acc + 1);
      check("t1_tput", last_acc - first_acc, 2);
      check("t1_occ0", qif.occ, 0);
      check("t1_sb_empty", sb_q.size(), 0);
      check("t1_idle", qif.busy, 0);

      // 2: drain of an empty queue
      qif.drain_start = 1'b1;
      step();
      qif.drain_start = 1'b0;
      check("t2_done", qif.drain_done, 1);
      check("t2_no_req", qif.deq_req, 0);
      step();
      check("t2_done_off", qif.drain_done, 0);
      check("t2_idle", qif.busy, 0);

      // 3: downstream backpressure holds the key and stops requests
      enq(16'hB001);
      enq(16'hB002);
      qif.drain_start = 1'b1;
      step();
      qif.drain_start = 1'b0;
      qif.out_ready   = 1'b1;
      #1;
      check("t3_req", qif.deq_req, 1);
      k0 = src_q.pop_front();
      sb_q.push_back(k0);
      qif.deq_ack = 1'b1;
      qif.deq_key = k0;
      step();
      qif.deq_ack   = 1'b0;
      qif.deq_key   = 16'hDEAD;
      qif.out_ready = 1'b0;
      #1;
      check("t3_req_drop", qif.deq_req, 0);
      check("t3_valid", qif.out_valid, 1);
      check("t3_occ1", qif.occ, 1);
      for (int i = 0; i < 3; i++) begin
         step();
         check("t3_key_hold", qif.out_key, k0);
         check("t3_req_low", qif.deq_req, 0);
      end
      drain_loop(60);
      check("t3_keys", keys_out, 2);
      check("t3_done_cnt", done_cnt, 1);
      check("t3_sb_empty", sb_q.size(), 0);

      // 4: overflow at full, ack without request
      for (int i = 0; i < 16; i++) enq(16'(16'hC000 + i));
      check("t4_occ16", qif.occ, 16);
      check("t4_no_ovf", qif.ovf_err, 0);
      qif.enq_fire = 1'b1;
      step();
      qif.enq_fire = 1'b0;
      check("t4_occ_sat", qif.occ, 16);
      check("t4_ovf", qif.ovf_err, 1);
      check("t4_no_unf", qif.unf_err, 0);
      qif.deq_ack = 1'b1;
      qif.deq_key = 16'h5555;
      step();
      qif.deq_ack = 1'b0;
      check("t4_occ_hold", qif.occ, 16);
      check("t4_unf", qif.unf_err, 1);
      check("t4_no_capture", qif.out_valid, 0);
      step();
      check("t4_ovf_sticky", qif.ovf_err, 1);
      do_reset();
      src_q.delete();
      check("t4_errs_clr", {qif.ovf_err, qif.unf_err}, 0);
      check("t4_occ_clr", qif.occ, 0);

      // 5: simultaneous enq/deq, then reset mid-drain
      for (int i = 0; i < 4; i++) enq(16'(16'hD000 + i));
      qif.drain_start = 1'b1;
      step();
      qif.drain_start = 1'b0;
      qif.out_ready   = 1'b1;
      qif.enq_fire    = 1'b1;
      #1;
      k0 = src_q.pop_front();
      qif.deq_ack = qif.deq_req;
      qif.deq_key = k0;
      step();
      qif.enq_fire = 1'b0;
      qif.deq_ack  = 1'b0;
      check("t5_occ_same", qif.occ, 4);
      check("t5_valid", qif.out_valid, 1);
      check("t5_key", qif.out_key, k0);
      rst = 1'b1;
      step();
      check("t5_busy", qif.busy, 0);
      check("t5_occ", qif.occ, 0);
      check("t5_valid_clr", qif.out_valid, 0);
      check("t5_key_clr", qif.out_key, 0);
      check("t5_req", qif.deq_req, 0);
      check("t5_done", qif.drain_done, 0);
      rst = 1'b0;
      dn = 0;
      for (int i = 0; i < 4; i++) begin
         step();
         if (qif.drain_done) dn++;
      end
      check("t5_no_done", dn, 0);
      src_q.delete();
      sb_q.delete();

      // 6: dequeue never acknowledged
      enq(16'hE001);
      qif.drain_start = 1'b1;
      step();
      qif.drain_start = 1'b0;
      qif.out_ready   = 1'b1;
      qif.deq_ack     = 1'b0;
`ifdef QQ_DRAIN_TIMEOUT_EN
      w = 0;
      while (!qif.timeout_err && w < 200) begin
         w++;
         step();
      end
      check("t6_to_cycles", w, QQ_TIMEOUT_CYC);
      check("t6_to_err", qif.timeout_err, 1);
      check("t6_flush_no_req", qif.deq_req, 0);
      step();
      check("t6_done", qif.drain_done, 1);
      check("t6_occ1", qif.occ, 1);
      step();
      check("t6_idle", qif.busy, 0);
      check("t6_to_sticky", qif.timeout_err, 1);
      src_q.delete();
`else
      for (int i = 0; i < 80; i++) step();
      check("t6_no_to", qif.timeout_err, 0);
      check("t6_still_req", qif.deq_req, 1);
      check("t6_busy", qif.busy, 1);
      check("t6_occ1", qif.occ, 1);
      drain_loop(40);
      check("t6_keys", keys_out, 1);
      check("t6_done_cnt", done_cnt, 1);
      check("t6_occ0", qif.occ, 0);
`endif

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
